// File: rtl/unif_buf_writer_0.sv
// Write side of the layer-0 unified buffer: packs a raster stream of int8 pixels,
// sixteen per 128-bit word, and issues masked word writes to the buffer RAM.
module unif_buf_writer_0 #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_write,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              ram_we,
    input  logic              ram_wready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din0,
    output logic [31:0]       ram_din1,
    output logic [31:0]       ram_din2,
    output logic [31:0]       ram_din3,
    output logic [15:0]       ram_wmask,
    output logic              busy,
    output logic              write_done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   pix_idx_r;
    logic [127:0]       pack_data_r;
    logic [15:0]        pack_mask_r;
    logic [127:0]       wr_data_r;

    logic [3:0]         off_s;
    logic [3:0]         lane_s;
    logic               last_pix_s;
    logic               completing_s;
    logic               accept_s;
    logic               free_s;
    logic [127:0]       pack_data_nxt_s;
    logic [15:0]        pack_mask_nxt_s;

    function automatic logic [127:0] insert_lane(input logic [127:0] word,
                                                 input logic [3:0]   lane,
                                                 input logic [7:0]   pix);
        logic [127:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = pix;
        return res;
    endfunction

    // Pixel 0 of each word sits in the most significant lane.
    assign off_s        = pix_idx_r[3:0];
    assign lane_s       = 4'd15 - off_s;
    assign last_pix_s   = (pix_idx_r == LAST_IDX);
    assign completing_s = (off_s == 4'd15) || last_pix_s;
    assign free_s       = ram_we && ram_wready;
    assign accept_s     = in_valid && in_ready;

    assign ram_din0 = wr_data_r[127:96];
    assign ram_din1 = wr_data_r[95:64];
    assign ram_din2 = wr_data_r[63:32];
    assign ram_din3 = wr_data_r[31:0];

    // Backpressure only when a completing beat would overwrite a still-pending write
    always_comb begin
        if (state_r == PACK) begin
            in_ready = !(completing_s && ram_we && !ram_wready);
        end else begin
            in_ready = 1'b0;
        end
    end

    // Merge the current beat into the pack word and mask
    always_comb begin
        pack_data_nxt_s = insert_lane(pack_data_r, lane_s, in_data);
        pack_mask_nxt_s = pack_mask_r | (16'd1 << lane_s);
    end

    // Control FSM, pack register and single-entry write register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            pix_idx_r   <= '0;
            pack_data_r <= '0;
            pack_mask_r <= 16'h0000;
            wr_data_r   <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wmask   <= 16'h0000;
            busy        <= 1'b0;
            write_done  <= 1'b0;
        end else begin
            if (free_s) begin
                ram_we <= 1'b0;
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start_write) begin
                        state_r     <= PACK;
                        pix_idx_r   <= '0;
                        pack_data_r <= '0;
                        pack_mask_r <= 16'h0000;
                        busy        <= 1'b1;
                        write_done  <= 1'b0;
                    end
                end
                PACK: begin
                    if (accept_s) begin
                        pix_idx_r <= pix_idx_r + ONE_IDX;
                        if (completing_s) begin
                            wr_data_r   <= pack_data_nxt_s;
                            ram_wmask   <= pack_mask_nxt_s;
                            ram_addr    <= ADDR_W'(BASE_ADDR) + ADDR_W'(pix_idx_r[CNT_W-1:4]);
                            ram_we      <= 1'b1;
                            pack_data_r <= '0;
                            pack_mask_r <= 16'h0000;
                        end else begin
                            pack_data_r <= pack_data_nxt_s;
                            pack_mask_r <= pack_mask_nxt_s;
                        end
                        if (last_pix_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!ram_we || free_s) begin
                        state_r    <= DONE;
                        busy       <= 1'b0;
                        write_done <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    write_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unif_buf_writer_0.sv
// Randomised self-checking bench for unif_buf_writer_0: a 32x32 instance at base 0
// and a 5x5 instance at base 0x100, checked against a word-packing reference model.
module tb_unif_buf_writer_0;

    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } wr_t;

    logic clk = 1'b0;
    logic reset, start_a, start_b, in_valid, ram_wready;
    logic [7:0] in_data;

    logic        rdy_a, we_a, busy_a, done_a;
    logic [15:0] addr_a, mask_a;
    logic [31:0] d0_a, d1_a, d2_a, d3_a;
    logic        rdy_b, we_b, busy_b, done_b;
    logic [15:0] addr_b, mask_b;
    logic [31:0] d0_b, d1_b, d2_b, d3_b;

    logic         sel = 1'b0;
    logic         cur_ready, cur_we, cur_busy, cur_done;
    logic [15:0]  cur_addr, cur_mask;
    logic [127:0] cur_data;

    int checks = 0;
    int errors = 0;
    int stab_err = 0;
    int we_idle_err = 0;
    logic [7:0] pix [1024];
    wr_t wlog[$];
    wr_t exp_q[$];
    logic prev_stall = 1'b0;
    wr_t  prev_w;

    always #5 clk = ~clk;

    unif_buf_writer_0 dut_a (
        .clk(clk), .reset(reset), .start_write(start_a), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .ram_we(we_a), .ram_wready(ram_wready), .ram_addr(addr_a),
        .ram_din0(d0_a), .ram_din1(d1_a), .ram_din2(d2_a), .ram_din3(d3_a),
        .ram_wmask(mask_a), .busy(busy_a), .write_done(done_a)
    );

    unif_buf_writer_0 #(.IMG_W(5), .IMG_H(5), .ADDR_W(16), .BASE_ADDR(256)) dut_b (
        .clk(clk), .reset(reset), .start_write(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .ram_we(we_b), .ram_wready(ram_wready), .ram_addr(addr_b),
        .ram_din0(d0_b), .ram_din1(d1_b), .ram_din2(d2_b), .ram_din3(d3_b),
        .ram_wmask(mask_b), .busy(busy_b), .write_done(done_b)
    );

    assign cur_ready = sel ? rdy_b : rdy_a;
    assign cur_we    = sel ? we_b : we_a;
    assign cur_busy  = sel ? busy_b : busy_a;
    assign cur_done  = sel ? done_b : done_a;
    assign cur_addr  = sel ? addr_b : addr_a;
    assign cur_mask  = sel ? mask_b : mask_a;
    assign cur_data  = sel ? {d0_b, d1_b, d2_b, d3_b} : {d0_a, d1_a, d2_a, d3_a};

    // Write monitor: logs accepted writes, watches hold-stability and stray ram_we
    always @(negedge clk) begin
        if (cur_we && ram_wready) wlog.push_back({cur_addr, cur_data, cur_mask});
        if (reset && prev_stall && ({cur_addr, cur_data, cur_mask} != prev_w)) stab_err <= stab_err + 1;
        if (cur_we && !cur_busy) we_idle_err <= we_idle_err + 1;
        prev_stall <= reset && cur_we && !ram_wready;
        prev_w     <= {cur_addr, cur_data, cur_mask};
    end

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Reference: pixel i lands in word base+i/16, byte lane 15-(i%16); unwritten lanes are zero.
    task automatic build_expected(input int npix, input int base);
        wr_t w;
        exp_q.delete();
        for (int wi = 0; wi < (npix + 15) / 16; wi++) begin
            w.addr = 16'(base + wi);
            w.data = '0;
            w.mask = 16'h0000;
            for (int i = wi * 16; i < npix && i < wi * 16 + 16; i++) begin
                w.data[(15 - (i % 16)) * 8 +: 8] = pix[i];
                w.mask[15 - (i % 16)] = 1'b1;
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic run_image(input int npix, input bit gaps, input int stall, input bit pulses,
                             input int abort_at, output bit saw31, output bit timeout,
                             output logic wd0, output logic wd1, output logic busy1);
        int idx, cyc, stall_left;
        bit started;
        saw31 = 1'b0; timeout = 1'b0; wd0 = 1'bx; wd1 = 1'bx; busy1 = 1'bx;
        wlog.delete();
        @(posedge clk); #1;
        set_start(1'b1); in_valid = 1'b0; ram_wready = 1'b1;
        @(posedge clk); #1;
        set_start(1'b0);
        idx = 0; cyc = 0; stall_left = stall; started = 1'b0;
        while (idx < npix && idx != abort_at && cyc < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = pix[idx];
            if (pulses) set_start($urandom_range(0, 5) == 0);
            if (stall > 0 && !started && cur_we) started = 1'b1;
            if (started && stall_left > 0) begin
                ram_wready = 1'b0;
                stall_left--;
            end else begin
                ram_wready = !(abort_at >= 0 && idx >= 32);
            end
            @(negedge clk);
            if (idx == 31 && in_valid && !cur_ready) saw31 = 1'b1;
            if (in_valid && cur_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        set_start(1'b0);
        if (cyc >= 5000) timeout = 1'b1;
        if (abort_at < 0 && !timeout) begin
            ram_wready = 1'b1;
            @(negedge clk); wd0 = cur_done;
            @(negedge clk); wd1 = cur_done; busy1 = cur_busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = 8'h00; ram_wready = 1'b1;
        #3;
        checks++;
        if ({rdy_a, we_a, busy_a, done_a, addr_a, mask_a, d0_a, d1_a, d2_a, d3_a} !== '0) begin
            errors++; $display("FAIL reset_a got we=%b rdy=%b busy=%b done=%b addr=%h mask=%h required all zero",
                               we_a, rdy_a, busy_a, done_a, addr_a, mask_a);
        end
        checks++;
        if ({rdy_b, we_b, busy_b, done_b, addr_b, mask_b, d0_b, d1_b, d2_b, d3_b} !== '0) begin
            errors++; $display("FAIL reset_b got we=%b rdy=%b busy=%b done=%b addr=%h mask=%h required all zero",
                               we_b, rdy_b, busy_b, done_b, addr_b, mask_b);
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_a, we_a, busy_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL idle_after_reset got rdy/we/busy/done=%b required 0000",
                               {rdy_a, we_a, busy_a, done_a});
        end
    endtask

    task automatic test_stream();
        bit s31, to; logic wd0, wd1, b1;
        sel = 1'b0;
        for (int i = 0; i < 1024; i++) pix[i] = 8'(i);
        run_image(1024, 1'b0, 0, 1'b0, -1, s31, to, wd0, wd1, b1);
        build_expected(1024, 0);
        checks++; if (to) begin errors++; $display("FAIL stream_timeout got timeout required none"); end
        checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL stream_count got %0d required %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                errors++; $display("FAIL stream_write[%0d] got %h %h %h required %h %h %h", i,
                                   wlog[i].addr, wlog[i].data, wlog[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
        if (wlog.size() > 0) begin
            checks++;
            if (wlog[0].data[127:96] !== 32'h00010203 || wlog[0].data[31:0] !== 32'h0C0D0E0F) begin
                errors++; $display("FAIL stream_word0 got din0=%h din3=%h required 00010203 0c0d0e0f",
                                   wlog[0].data[127:96], wlog[0].data[31:0]);
            end
        end
        checks++;
        if (wd0 !== 1'b0 || wd1 !== 1'b1 || b1 !== 1'b0) begin
            errors++; $display("FAIL stream_done_timing got wd@N=%b wd@N+1=%b busy=%b required 0 1 0", wd0, wd1, b1);
        end
    endtask

    task automatic test_stall();
        bit s31, to; logic wd0, wd1, b1;
        sel = 1'b0;
        for (int i = 0; i < 1024; i++) pix[i] = 8'($urandom);
        run_image(1024, 1'b0, 20, 1'b0, -1, s31, to, wd0, wd1, b1);
        build_expected(1024, 0);
        checks++; if (to) begin errors++; $display("FAIL stall_timeout got timeout required none"); end
        checks++; if (!s31) begin errors++; $display("FAIL stall_beat31 got in_ready never low at beat 31 required low"); end
        checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d required %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_write[%0d] got %h %h %h required %h %h %h", i,
                                   wlog[i].addr, wlog[i].data, wlog[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_hold got %0d changes required 0", stab_err); end
        checks++;
        if (wd0 !== 1'b0 || wd1 !== 1'b1) begin
            errors++; $display("FAIL stall_done_timing got %b %b required 0 1", wd0, wd1);
        end
    endtask

    task automatic test_partial();
        bit s31, to; logic wd0, wd1, b1;
        sel = 1'b1;
        for (int i = 0; i < 25; i++) pix[i] = 8'($urandom_range(1, 255));
        run_image(25, 1'b0, 0, 1'b0, -1, s31, to, wd0, wd1, b1);
        build_expected(25, 256);
        checks++; if (to) begin errors++; $display("FAIL partial_timeout got timeout required none"); end
        checks++; if (wlog.size() != 2) begin errors++; $display("FAIL partial_count got %0d required 2", wlog.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                errors++; $display("FAIL partial_write[%0d] got %h %h %h required %h %h %h", i,
                                   wlog[i].addr, wlog[i].data, wlog[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
        if (wlog.size() >= 2) begin
            checks++;
            if (wlog[1].mask !== 16'hFF80 || wlog[1].data[55:0] !== 56'h0 || wlog[1].addr !== 16'h0101) begin
                errors++; $display("FAIL partial_tail got addr=%h mask=%h low=%h required 0101 ff80 0",
                                   wlog[1].addr, wlog[1].mask, wlog[1].data[55:0]);
            end
        end
        checks++;
        if (wd0 !== 1'b0 || wd1 !== 1'b1) begin
            errors++; $display("FAIL partial_done_timing got %b %b required 0 1", wd0, wd1);
        end
    endtask

    task automatic test_gaps();
        bit s31, to; logic wd0, wd1, b1;
        sel = 1'b0;
        for (int i = 0; i < 1024; i++) pix[i] = 8'(i);
        run_image(1024, 1'b1, 0, 1'b1, -1, s31, to, wd0, wd1, b1);
        build_expected(1024, 0);
        checks++; if (to) begin errors++; $display("FAIL gaps_timeout got timeout required none"); end
        checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL gaps_count got %0d required %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                errors++; $display("FAIL gaps_write[%0d] got %h %h %h required %h %h %h", i,
                                   wlog[i].addr, wlog[i].data, wlog[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
        checks++;
        if (wd0 !== 1'b0 || wd1 !== 1'b1) begin
            errors++; $display("FAIL gaps_done_timing got %b %b required 0 1", wd0, wd1);
        end
    endtask

    task automatic test_reset_mid();
        bit s31, to; logic wd0, wd1, b1;
        sel = 1'b0;
        for (int i = 0; i < 1024; i++) pix[i] = 8'($urandom);
        run_image(1024, 1'b0, 0, 1'b0, 37, s31, to, wd0, wd1, b1);
        checks++; if (to) begin errors++; $display("FAIL abort_timeout got timeout required none"); end
        checks++; if (cur_we !== 1'b1) begin errors++; $display("FAIL abort_pending got ram_we=%b required 1", cur_we); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cur_we, cur_ready, cur_busy} !== 3'b000) begin
            errors++; $display("FAIL abort_async got we/rdy/busy=%b required 000", {cur_we, cur_ready, cur_busy});
        end
        @(posedge clk); #1;
        reset = 1'b1; ram_wready = 1'b1;
        wlog.delete();
        repeat (5) @(negedge clk);
        checks++;
        if (wlog.size() != 0 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
            errors++; $display("FAIL abort_quiet got writes=%0d busy=%b done=%b required 0 0 0", wlog.size(), cur_busy, cur_done);
        end
        for (int i = 0; i < 1024; i++) pix[i] = 8'($urandom);
        run_image(1024, 1'b0, 0, 1'b0, -1, s31, to, wd0, wd1, b1);
        build_expected(1024, 0);
        checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL restart_count got %0d required %0d", wlog.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_q[i]) begin
                errors++; $display("FAIL restart_write[%0d] got %h %h %h required %h %h %h", i,
                                   wlog[i].addr, wlog[i].data, wlog[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
        end
        checks++; if (we_idle_err != 0) begin errors++; $display("FAIL we_outside_busy got %0d cycles required 0", we_idle_err); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_partial();
        test_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
